multicycle_control: RTL

- Moore/Mealy control FSM that sequences the multi-cycle RISC datapath: instruction fetch into the instruction register, decode, execute, memory access and writeback.
- Drives IR_Write and all other datapath enables.
- Handles variable-latency memory through a ready handshake, with a wait-state timeout.
- Traps on illegal opcodes and bus timeouts.

---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for the multi-cycle RISC datapath. Sequences fetch, decode,
// execute, memory access and writeback, drives every datapath enable, waits
// on a variable-latency memory through mem_ready with a bounded wait-state
// counter, and traps on illegal opcodes or bus timeouts.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   opcode[5:0]     instruction bits [31:26] from the instruction register
//   zero            ALU zero flag (PC write gating is done in the datapath)
//   mem_ready       memory completes the current access this cycle
//   IR_Write, PC_Write, PC_Write_Cond, pc_source[1:0], IorD, mem_read,
//   mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0]     datapath controls, all 0 while reset is high
//   state[3:0]      current state encoding (debug)
//   illegal_op      sticky, set when decode traps on an unknown opcode
//   bus_error       sticky, set when a memory wait times out
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IR_Write,
    output logic       PC_Write,
    output logic       PC_Write_Cond,
    output logic [1:0] pc_source,
    output logic       IorD,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             illegal_op_r;
    logic             bus_error_r;
    logic             set_illegal_s;
    logic             set_bus_err_s;
    logic             wait_state_s;
    logic             timeout_s;

    logic       ir_write_s, pc_write_s, pc_write_cond_s, iord_s;
    logic       mem_read_s, mem_write_s, reg_write_s, reg_dst_s;
    logic       mem_to_reg_s, alu_src_a_s;
    logic [1:0] pc_source_s, alu_src_b_s, alu_op_s;

    // The zero flag only matters to the datapath's conditional PC write.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    assign wait_state_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    // mem_ready on the limit cycle wins over the timeout.
    assign timeout_s    = (WAIT_LIMIT != 32'sd0) && !mem_ready && (wait_cnt_r == LIMIT_C);

    // State register, wait counter and sticky trap flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= FETCH;
            wait_cnt_r   <= {CNT_W{1'b0}};
            illegal_op_r <= 1'b0;
            bus_error_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) || mem_ready) begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end else if (wait_state_s && (wait_cnt_r != CNT_MAX_C)) begin
                wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            illegal_op_r <= illegal_op_r | set_illegal_s;
            bus_error_r  <= bus_error_r | set_bus_err_s;
        end
    end

    // Next-state selection and trap-flag set requests.
    always_comb begin
        state_next_s  = state_r;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        case (state_r)
            FETCH, MEM_RD, MEM_WR: begin
                if (mem_ready) begin
                    if (state_r == FETCH) begin
                        state_next_s = DECODE;
                    end else if (state_r == MEM_RD) begin
                        state_next_s = MEM_WB;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else if (timeout_s) begin
                    state_next_s  = TRAP;
                    set_bus_err_s = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next_s = R_EXEC;
                    OP_LW, OP_SW:  state_next_s = MEM_ADDR;
                    OP_BEQ:        state_next_s = BRANCH;
                    OP_J:          state_next_s = JUMP;
                    OP_ADDI:       state_next_s = I_EXEC;
                    default: begin
                        state_next_s  = TRAP;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_next_s = MEM_RD;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            R_EXEC:                        state_next_s = R_WB;
            I_EXEC:                        state_next_s = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_next_s = FETCH;
            TRAP:                          state_next_s = TRAP;
            // Unused encodings fall into the trap rather than wander.
            default:                       state_next_s = TRAP;
        endcase
    end

    // Per-state datapath controls; FETCH is Mealy on mem_ready.
    always_comb begin
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_source_s     = 2'b00;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        case (state_r)
            FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            DECODE:   alu_src_b_s = 2'b11;
            MEM_ADDR, I_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            MEM_RD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            MEM_WR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            R_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
            end
            JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            I_WB:     reg_write_s = 1'b1;
            default:  ir_write_s  = 1'b0;
        endcase
    end

    assign {IR_Write, PC_Write, PC_Write_Cond, pc_source, IorD, mem_read, mem_write,
            reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op} =
        reset ? 16'h0000
              : {ir_write_s, pc_write_s, pc_write_cond_s, pc_source_s, iord_s,
                 mem_read_s, mem_write_s, reg_write_s, reg_dst_s, mem_to_reg_s,
                 alu_src_a_s, alu_src_b_s, alu_op_s};

    assign state      = state_r;
    assign illegal_op = illegal_op_r;
    assign bus_error  = bus_error_r;

endmodule
